anita3_event_builder: RTL and testbench

Upstream stage of the TURF dual event buffer.
- On each trigger it latches the trigger's header fields and waits for the target buffer (0 or 1, alternating) to be free.
- It then writes a fixed 64-word, 16-bit event record into that buffer and pulses `event_done_o` so the buffer marks itself active.
- It owns write-side buffer ping-pong and counts triggers dropped while it is full.

---
 rtl/anita3_event_pkg.sv | 31 +++
 rtl/anita3_event_word_mux.sv | 36 +++
 rtl/anita3_event_builder.sv | 170 +++++++++++++++++
 tb/tb_anita3_event_builder.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/anita3_event_pkg.sv
// Shared types and constants for the ANITA-3 event builder: FSM states,
// record word indices and the default record marker.
package anita3_event_pkg;

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_BUF = 2'd1,
    S_WRITE    = 2'd2,
    S_DONE     = 2'd3
  } state_e;

  localparam logic [5:0] W_MARKER   = 6'd0;
  localparam logic [5:0] W_EVT_LO   = 6'd1;
  localparam logic [5:0] W_EVT_HI   = 6'd2;
  localparam logic [5:0] W_TIME_LO  = 6'd3;
  localparam logic [5:0] W_TIME_HI  = 6'd4;
  localparam logic [5:0] W_PPS      = 6'd5;
  localparam logic [5:0] W_C3PO_LO  = 6'd6;
  localparam logic [5:0] W_C3PO_HI  = 6'd7;
  localparam logic [5:0] W_PATTERN  = 6'd8;
  localparam logic [5:0] W_DROPPED  = 6'd9;
  localparam logic [5:0] W_CKSUM    = 6'd63;

  localparam logic [15:0] DEFAULT_MARKER = 16'hA3EB;

  // Buffer-local write address; bit 7 is reserved and always zero.
  function automatic logic [7:0] wr_addr(input logic buf_sel, input logic [5:0] word);
    return {1'b0, buf_sel, word};
  endfunction

endpackage

// File: rtl/anita3_event_word_mux.sv
// Selects the 16-bit content of one event record word from the held trigger
// header. The checksum word is produced by the builder, so it reads zero here.
module anita3_event_word_mux
  import anita3_event_pkg::*;
#(
  parameter logic [15:0] MARKER = DEFAULT_MARKER
) (
  input  logic [5:0]  word_i,
  input  logic [31:0] evt_num_i,
  input  logic [31:0] trig_time_i,
  input  logic [15:0] pps_num_i,
  input  logic [31:0] c3po_i,
  input  logic [15:0] trig_pattern_i,
  input  logic [15:0] dropped_i,
  output logic [15:0] dat_o
);

  // Word index to record content.
  always_comb begin
    dat_o = 16'h0000;
    case (word_i)
      W_MARKER:  dat_o = MARKER;
      W_EVT_LO:  dat_o = evt_num_i[15:0];
      W_EVT_HI:  dat_o = evt_num_i[31:16];
      W_TIME_LO: dat_o = trig_time_i[15:0];
      W_TIME_HI: dat_o = trig_time_i[31:16];
      W_PPS:     dat_o = pps_num_i;
      W_C3PO_LO: dat_o = c3po_i[15:0];
      W_C3PO_HI: dat_o = c3po_i[31:16];
      W_PATTERN: dat_o = trig_pattern_i;
      W_DROPPED: dat_o = dropped_i;
      default:   dat_o = 16'h0000;
    endcase
  end

endmodule

// File: rtl/anita3_event_builder.sv
// Builds one fixed 64-word event record per accepted trigger into the
// alternating halves of the TURF dual event buffer.
module anita3_event_builder
  import anita3_event_pkg::*;
#(
  parameter logic [15:0] MARKER = DEFAULT_MARKER
) (
  input  logic        clk33_i,
  input  logic        rst_n_i,
  input  logic        trig_i,
  input  logic [31:0] evt_num_i,
  input  logic [31:0] trig_time_i,
  input  logic [15:0] pps_num_i,
  input  logic [31:0] c3po_i,
  input  logic [15:0] trig_pattern_i,
  input  logic [1:0]  buffer_active_i,
  output logic [7:0]  event_wr_addr_o,
  output logic [15:0] event_wr_dat_o,
  output logic        event_wr_o,
  output logic        event_done_o,
  output logic        busy_o,
  output logic [15:0] dropped_o,
  output logic [31:0] status_o
);

  state_e      state_q;
  logic        wr_buf_q;
  logic        hold_valid_q;
  logic [31:0] evt_num_q;
  logic [31:0] trig_time_q;
  logic [15:0] pps_num_q;
  logic [31:0] c3po_q;
  logic [15:0] pattern_q;
  logic [15:0] hold_drop_q;
  logic [15:0] dropped_q;
  logic [5:0]  word_q;
  logic [15:0] cksum_q;
  logic [7:0]  addr_q;
  logic [15:0] dat_q;
  logic        wr_q;
  logic        done_q;

  logic        accept_d;
  logic [5:0]  word_d;
  logic [15:0] cksum_d;
  logic [15:0] mux_dat_d;

  // Acceptance, next word index and running checksum.
  always_comb begin
    accept_d = trig_i && (!hold_valid_q || (state_q == S_DONE));
    if (state_q == S_WRITE) begin
      word_d = word_q + 6'd1;
    end else begin
      word_d = 6'd0;
    end
    // dat_q holds the word on the bus this cycle; fold it in as it is written.
    cksum_d = cksum_q + dat_q;
  end

  anita3_event_word_mux #(
    .MARKER         (MARKER)
  ) u_word_mux (
    .word_i         (word_d),
    .evt_num_i      (evt_num_q),
    .trig_time_i    (trig_time_q),
    .pps_num_i      (pps_num_q),
    .c3po_i         (c3po_q),
    .trig_pattern_i (pattern_q),
    .dropped_i      (hold_drop_q),
    .dat_o          (mux_dat_d)
  );

  // Hold register, drop counter, record FSM and registered write port.
  always_ff @(posedge clk33_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      wr_buf_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      evt_num_q    <= 32'h0000_0000;
      trig_time_q  <= 32'h0000_0000;
      pps_num_q    <= 16'h0000;
      c3po_q       <= 32'h0000_0000;
      pattern_q    <= 16'h0000;
      hold_drop_q  <= 16'h0000;
      dropped_q    <= 16'h0000;
      word_q       <= 6'd0;
      cksum_q      <= 16'h0000;
      addr_q       <= 8'h00;
      dat_q        <= 16'h0000;
      wr_q         <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      if (accept_d) begin
        hold_valid_q <= 1'b1;
        evt_num_q    <= evt_num_i;
        trig_time_q  <= trig_time_i;
        pps_num_q    <= pps_num_i;
        c3po_q       <= c3po_i;
        pattern_q    <= trig_pattern_i;
        hold_drop_q  <= dropped_q;
      end else if (state_q == S_DONE) begin
        hold_valid_q <= 1'b0;
      end else begin
        hold_valid_q <= hold_valid_q;
      end

      if (trig_i && !accept_d && (dropped_q != 16'hFFFF)) begin
        dropped_q <= dropped_q + 16'd1;
      end else begin
        dropped_q <= dropped_q;
      end

      wr_q   <= 1'b0;
      done_q <= 1'b0;
      addr_q <= 8'h00;
      dat_q  <= 16'h0000;

      case (state_q)
        S_IDLE: begin
          if (hold_valid_q) begin
            state_q <= S_WAIT_BUF;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_WAIT_BUF: begin
          if (!buffer_active_i[wr_buf_q]) begin
            state_q <= S_WRITE;
            word_q  <= 6'd0;
            cksum_q <= 16'h0000;
            wr_q    <= 1'b1;
            addr_q  <= wr_addr(wr_buf_q, 6'd0);
            dat_q   <= mux_dat_d;
          end else begin
            state_q <= S_WAIT_BUF;
          end
        end
        S_WRITE: begin
          cksum_q <= cksum_d;
          if (word_q == W_CKSUM) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            addr_q  <= wr_addr(wr_buf_q, W_CKSUM);
          end else begin
            word_q <= word_d;
            wr_q   <= 1'b1;
            addr_q <= wr_addr(wr_buf_q, word_d);
            dat_q  <= (word_d == W_CKSUM) ? cksum_d : mux_dat_d;
          end
        end
        S_DONE: begin
          wr_buf_q <= ~wr_buf_q;
          state_q  <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign event_wr_addr_o = addr_q;
  assign event_wr_dat_o  = dat_q;
  assign event_wr_o      = wr_q;
  assign event_done_o    = done_q;
  assign busy_o          = hold_valid_q;
  assign dropped_o       = dropped_q;
  assign status_o        = {dropped_q, 12'h000, hold_valid_q, wr_buf_q, state_q};

endmodule

// File: tb/tb_anita3_event_builder.sv
// Self-checking bench for anita3_event_builder: directed table plus corner
// sequences and a randomized run against a record-level reference model.
module tb_anita3_event_builder;

  logic        clk = 1'b0;
  logic        rst_n, trig;
  logic [31:0] evt, ttime, c3po;
  logic [15:0] pps, pat;
  logic [1:0]  act;
  logic [7:0]  addr;
  logic [15:0] dat, dropped;
  logic        wr, done, busy;
  logic [31:0] status;

  always #15 clk = ~clk;

  anita3_event_builder dut (
    .clk33_i         (clk),
    .rst_n_i         (rst_n),
    .trig_i          (trig),
    .evt_num_i       (evt),
    .trig_time_i     (ttime),
    .pps_num_i       (pps),
    .c3po_i          (c3po),
    .trig_pattern_i  (pat),
    .buffer_active_i (act),
    .event_wr_addr_o (addr),
    .event_wr_dat_o  (dat),
    .event_wr_o      (wr),
    .event_done_o    (done),
    .busy_o          (busy),
    .dropped_o       (dropped),
    .status_o        (status)
  );

  typedef struct packed {
    logic [31:0] evt;
    logic [31:0] ttime;
    logic [15:0] pps;
    logic [31:0] c3po;
    logic [15:0] pat;
    logic [15:0] drop;
  } hdr_t;

  typedef struct packed {
    logic [31:0] evt;
    logic [31:0] ttime;
    logic [15:0] pps;
    logic [31:0] c3po;
    logic [15:0] pat;
    logic [15:0] w1;
    logic [15:0] w2;
    logic [15:0] w9;
    logic [15:0] cksum;
    logic        exp_buf;
  } vec_t;

  hdr_t        exp_q[$];
  int          tests = 0, fails = 0, cyc = 0;
  bit          m_full = 1'b0, m_buf = 1'b0, done_prev = 1'b0;
  logic [15:0] m_drop = 16'h0000;
  logic [1:0]  act_seen;
  logic [15:0] rec [64];
  int          wr_cnt = 0, n_wr = 0, n_done = 0, first_wr_cyc = 0, done_cyc = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  function automatic logic [15:0] exp_word(input hdr_t h, input int w);
    case (w)
      0: return 16'hA3EB;
      1: return h.evt[15:0];
      2: return h.evt[31:16];
      3: return h.ttime[15:0];
      4: return h.ttime[31:16];
      5: return h.pps;
      6: return h.c3po[15:0];
      7: return h.c3po[31:16];
      8: return h.pat;
      9: return h.drop;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] exp_cksum(input hdr_t h);
    logic [15:0] s = 16'h0000;
    for (int i = 0; i < 63; i++) s = s + exp_word(h, i);
    return s;
  endfunction

  task automatic check_record(input hdr_t h);
    int bad = -1;
    logic [15:0] want;
    for (int i = 0; i < 64; i++) begin
      want = (i == 63) ? exp_cksum(h) : exp_word(h, i);
      if (rec[i] !== want && bad < 0) bad = i;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      want = (bad == 63) ? exp_cksum(h) : exp_word(h, bad);
      $display("FAIL record word %0d: got %h, expected %h (cycle %0d)", bad, rec[bad], want, cyc);
    end
  endtask

  // One clock: advance the reference model with the driven inputs, then observe.
  task automatic step();
    hdr_t h;
    act_seen = act;
    if (!rst_n) begin
      m_full = 1'b0; m_drop = 16'h0000; m_buf = 1'b0; wr_cnt = 0;
      exp_q.delete();
    end else if (trig) begin
      if (!m_full || done_prev) begin
        h = '{evt: evt, ttime: ttime, pps: pps, c3po: c3po, pat: pat, drop: m_drop};
        exp_q.push_back(h);
        m_full = 1'b1;
      end else if (m_drop != 16'hFFFF) begin
        m_drop = m_drop + 16'd1;
      end
    end else if (done_prev) begin
      m_full = 1'b0;
    end
    @(posedge clk);
    #1;
    cyc++;
    done_prev = done;
    chk("busy", busy, m_full);
    chk("dropped", dropped, m_drop);
    if (wr) begin
      if (addr[5:0] == 6'd0) begin
        wr_cnt = 0;
        first_wr_cyc = cyc;
        chk("buf_free_at_start", act_seen[m_buf], 1'b0);
      end
      chk("wr_addr", addr, {1'b0, m_buf, wr_cnt[5:0]});
      rec[addr[5:0]] = dat;
      wr_cnt++;
      n_wr++;
    end
    if (done) begin
      done_cyc = cyc;
      n_done++;
      chk("done_addr", addr, {1'b0, m_buf, 6'd63});
      chk("done_wr_count", wr_cnt, 64);
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: got a done pulse, expected none (cycle %0d)", cyc);
      end else begin
        check_record(exp_q.pop_front());
      end
      m_buf = ~m_buf;
      wr_cnt = 0;
    end
  endtask

  task automatic set_hdr(input logic [31:0] e, input logic [31:0] t, input logic [15:0] p,
                         input logic [31:0] c, input logic [15:0] pt);
    evt = e; ttime = t; pps = p; c3po = c; pat = pt;
  endtask

  task automatic rand_hdr();
    set_hdr($urandom, $urandom, 16'($urandom), $urandom, 16'($urandom));
  endtask

  // Returns T, the cycle in which the trigger strobe was high.
  task automatic trigger(output int t);
    trig = 1'b1;
    step();
    t = cyc - 1;
    trig = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n0 = n_done;
    int k = 0;
    while (n_done == n0 && k < limit) begin
      step();
      k++;
    end
    tests++;
    if (n_done == n0) begin
      fails++;
      $display("FAIL done_timeout: got no done within %0d cycles, expected one (cycle %0d)", limit, cyc);
    end
  endtask

  task automatic wait_wr(input int limit);
    int k = 0;
    while (!wr && k < limit) begin
      step();
      k++;
    end
    chk("write_seen", wr, 1'b1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  vec_t vecs [2];
  int   t, d, n0, k;
  int   tmr [2];

  initial begin
    vecs[0] = '{evt: 32'h12345678, ttime: 32'hCAFEF00D, pps: 16'h0042, c3po: 32'h01F78A40,
                pat: 16'h8001, w1: 16'h5678, w2: 16'h1234, w9: 16'h0000, cksum: 16'hD41C, exp_buf: 1'b0};
    vecs[1] = '{evt: 32'hFFFFFFFF, ttime: 32'hFFFFFFFF, pps: 16'hFFFF, c3po: 32'hFFFFFFFF,
                pat: 16'hFFFF, w1: 16'hFFFF, w2: 16'hFFFF, w9: 16'h0000, cksum: 16'hA3E3, exp_buf: 1'b1};

    rst_n = 1'b0; trig = 1'b0; act = 2'b00;
    set_hdr(32'h0, 32'h0, 16'h0, 32'h0, 16'h0);
    do_reset();
    chk("reset_addr", addr, 8'h00);
    chk("reset_dat", dat, 16'h0000);
    chk("reset_wr", wr, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_status", status, 32'h0000_0000);

    // Table: single records with both buffers free, exact latency.
    for (int i = 0; i < 2; i++) begin
      set_hdr(vecs[i].evt, vecs[i].ttime, vecs[i].pps, vecs[i].c3po, vecs[i].pat);
      trigger(t);
      wait_done(200);
      chk("first_write_time", first_wr_cyc, t + 3);
      chk("done_time", done_cyc, t + 67);
      chk("done_buf", addr[6], vecs[i].exp_buf);
      chk("word1", rec[1], vecs[i].w1);
      chk("word2", rec[2], vecs[i].w2);
      chk("word9", rec[9], vecs[i].w9);
      chk("word63", rec[63], vecs[i].cksum);
      step();
      chk("done_one_cycle", done, 1'b0);
    end

    // Third record waits on busy buffer 0; triggers while full are dropped.
    act = 2'b01;
    set_hdr(32'h0, 32'h0, 16'h0, 32'h0, 16'h0);
    trigger(t);
    repeat (3) step();
    n0 = n_wr;
    act = 2'b11;
    repeat (3) begin
      trig = 1'b1; step();
      trig = 1'b0; step();
    end
    chk("wait_state", status[1:0], 2'b01);
    chk("wait_busy", busy, 1'b1);
    chk("wait_dropped", dropped, 16'd3);
    act = 2'b01;
    repeat (4) step();
    chk("no_writes_while_active", n_wr, n0);
    act = 2'b00;
    step();
    chk("start_after_clear", wr, 1'b1);
    chk("start_addr", addr, 8'h00);
    wait_done(100);
    chk("wait_rec_word9", rec[9], 16'h0000);
    chk("wait_rec_cksum", rec[63], 16'hA3EB);

    rand_hdr();
    trigger(t);
    wait_done(200);
    chk("latched_drop_word9", rec[9], 16'd3);

    // Trigger coincident with DONE is accepted without a drop.
    rand_hdr();
    trigger(t);
    k = 0;
    while (!done && k < 200) begin step(); k++; end
    chk("coincident_done_seen", done, 1'b1);
    d = cyc;
    rand_hdr();
    trig = 1'b1; step(); trig = 1'b0;
    chk("coincident_busy", busy, 1'b1);
    chk("coincident_no_drop", dropped, 16'd3);
    wait_wr(20);
    chk("coincident_first_write", first_wr_cyc, d + 3);
    chk("coincident_other_buf", addr, 8'h40);
    wait_done(200);

    // Reset in the middle of a record, together with a trigger.
    rand_hdr();
    trigger(t);
    k = 0;
    while (!(wr && addr[5:0] == 6'd30) && k < 200) begin step(); k++; end
    chk("reached_word30", addr[5:0], 6'd30);
    rst_n = 1'b0; trig = 1'b1;
    step();
    rst_n = 1'b1; trig = 1'b0;
    chk("abort_addr", addr, 8'h00);
    chk("abort_dat", dat, 16'h0000);
    chk("abort_wr", wr, 1'b0);
    chk("abort_done", done, 1'b0);
    chk("abort_status", status, 32'h0000_0000);
    n0 = n_done;
    repeat (80) step();
    chk("no_done_after_abort", n_done, n0);
    rand_hdr();
    trigger(t);
    wait_wr(20);
    chk("after_abort_addr", addr, 8'h00);
    wait_done(200);

    // Saturating drop counter with both buffers held busy.
    do_reset();
    act = 2'b11;
    rand_hdr();
    trigger(t);
    trig = 1'b1;
    repeat (70000) step();
    trig = 1'b0;
    step();
    chk("drop_saturate", dropped, 16'hFFFF);
    chk("saturate_state", status[1:0], 2'b01);
    act = 2'b00;
    wait_done(200);

    // Randomized traffic with an emulated downstream buffer.
    do_reset();
    tmr[0] = 0; tmr[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      trig = ($urandom_range(0, 29) == 0) || (done_prev && $urandom_range(0, 1) == 1);
      if (trig) rand_hdr();
      step();
      if (done) begin
        act[addr[6]] = 1'b1;
        tmr[addr[6]] = $urandom_range(0, 150);
      end
      for (int b = 0; b < 2; b++) begin
        if (act[b]) begin
          if (tmr[b] == 0) act[b] = 1'b0;
          else tmr[b] = tmr[b] - 1;
        end
      end
    end
    trig = 1'b0;
    act = 2'b00;
    k = 0;
    while ((busy || exp_q.size() != 0) && k < 400) begin step(); k++; end
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
